// File: rtl/sha_stream_padder.sv
// SHA-256 message padder: byte stream in, 512-bit padded blocks out, with first/last block flags.
// Optional SHA_PAD_BLKCNT_EN adds blk_index, the 0-based block number within the current message.
module sha_stream_padder #(
    parameter int unsigned BLK_BITS = 512,
    parameter int unsigned LEN_BITS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic [BLK_BITS-1:0] blk_data,
    output logic                blk_first,
    output logic                blk_last
`ifdef SHA_PAD_BLKCNT_EN
    ,
    output logic [15:0]         blk_index
`endif
);

    localparam int unsigned IDX_W     = 6;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned LSB_W     = 9;
    localparam int unsigned LAST_IDX  = 63;
    localparam int unsigned LEN_START = 56;

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_PAD    = 2'd1,
        S_LEN    = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t                state;
    state_t                ret;
    logic [BLK_BITS-1:0]   buffer;
    logic [IDX_W-1:0]      idx;
    logic [LEN_BITS-1:0]   bitlen;
    logic                  first_pend;
    logic [LSB_W-1:0]      byte_lsb_c;

    // Byte idx sits at bits [511-8*idx -: 8]; its lsb is 8*(63-idx).
    assign byte_lsb_c = {~idx, 3'b000};
    assign blk_data   = buffer;

    // Padder state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ACCEPT;
            ret        <= S_ACCEPT;
            buffer     <= '0;
            idx        <= '0;
            bitlen     <= '0;
            first_pend <= 1'b1;
            in_ready   <= 1'b1;
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
`ifdef SHA_PAD_BLKCNT_EN
            blk_index  <= '0;
`endif
        end else begin
            case (state)
                S_ACCEPT: begin
                    if (in_valid && in_ready) begin
                        buffer[byte_lsb_c +: BYTE_W] <= in_data;
                        idx    <= idx + IDX_W'(1);
                        bitlen <= bitlen + LEN_BITS'(8);
                        if (idx == IDX_W'(LAST_IDX)) begin
                            // Block is full: ship it, then pad in a fresh block if that was the end.
                            state     <= S_EMIT;
                            ret       <= in_last ? S_PAD : S_ACCEPT;
                            in_ready  <= 1'b0;
                            blk_valid <= 1'b1;
                            blk_first <= first_pend;
                            blk_last  <= 1'b0;
                        end else if (in_last) begin
                            state    <= S_PAD;
                            in_ready <= 1'b0;
                        end
                    end
                end

                S_PAD: begin
                    buffer[byte_lsb_c +: BYTE_W] <= 8'h80;
                    if (idx < IDX_W'(LEN_START)) begin
                        buffer[LEN_BITS-1:0] <= bitlen;
                        blk_last             <= 1'b1;
                    end else begin
                        // No room for the length field; it goes in an extra block.
                        ret <= S_LEN;
                    end
                    state     <= S_EMIT;
                    blk_valid <= 1'b1;
                    blk_first <= first_pend;
                end

                S_LEN: begin
                    buffer[LEN_BITS-1:0] <= bitlen;
                    blk_last             <= 1'b1;
                    state                <= S_EMIT;
                    blk_valid            <= 1'b1;
                    blk_first            <= first_pend;
                end

                S_EMIT: begin
                    if (blk_valid && blk_ready) begin
                        buffer     <= '0;
                        idx        <= '0;
                        first_pend <= 1'b0;
                        blk_valid  <= 1'b0;
                        blk_first  <= 1'b0;
                        blk_last   <= 1'b0;
`ifdef SHA_PAD_BLKCNT_EN
                        if (blk_last) begin
                            blk_index <= '0;
                        end else if (blk_index != 16'hFFFF) begin
                            blk_index <= blk_index + 16'd1;
                        end
`endif
                        if (blk_last) begin
                            bitlen     <= '0;
                            first_pend <= 1'b1;
                            state      <= S_ACCEPT;
                            in_ready   <= 1'b1;
                        end else begin
                            state    <= ret;
                            in_ready <= (ret == S_ACCEPT);
                        end
                    end
                end

                default: begin
                    state    <= S_ACCEPT;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_stream_padder.sv
// Randomised self-checking bench for sha_stream_padder against a FIPS 180-4 padding model.
// Compare blk_index as well when built with SHA_PAD_BLKCNT_EN.
module tb_sha_stream_padder;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [511:0] data;
        logic         first;
        logic         last;
        logic [15:0]  index;
    } blk_t;
    typedef blk_t blk_q_t[$];

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
`ifdef SHA_PAD_BLKCNT_EN
    logic [15:0]  blk_index;
`endif

    int total = 0;
    int bad   = 0;

    sha_stream_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .blk_last  (blk_last)
`ifdef SHA_PAD_BLKCNT_EN
        ,
        .blk_index (blk_index)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are read 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: message || 0x80 || zeros || 64-bit length, cut into 64-byte blocks.
    function automatic blk_q_t model_blocks(input byte_q_t msg);
        byte_q_t      p;
        blk_q_t       q;
        blk_t         b;
        logic [63:0]  bits;
        int           nb;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        nb = p.size() / 64;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b.data[511 - 8 * j -: 8] = p[k * 64 + j];
            b.first = (k == 0);
            b.last  = (k == nb - 1);
            b.index = 16'(k);
            q.push_back(b);
        end
        return q;
    endfunction

    // Drives one message and collects every block handed over, up to the last one.
    task automatic run_msg(input byte_q_t msg, input int vpct, input int rpct,
                           output blk_q_t got, output int unstable, output bit timeout);
        got      = {};
        unstable = 0;
        timeout  = 1'b0;
        fork
            begin
                int i   = 0;
                int cyc = 0;
                while (i < msg.size() && cyc < 5000) begin
                    in_valid = ($urandom_range(99) < vpct);
                    in_data  = msg[i];
                    in_last  = (i == msg.size() - 1);
                    if (in_valid && in_ready) i++;
                    step();
                    cyc++;
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
                if (i < msg.size()) timeout = 1'b1;
            end
            begin
                int   cyc    = 0;
                bit   done   = 1'b0;
                bit   prev_v = 1'b0;
                blk_t prev   = '0;
                blk_t cur;
                while (!done && cyc < 5000) begin
                    blk_ready = ($urandom_range(99) < rpct);
                    cur.data  = blk_data;
                    cur.first = blk_first;
                    cur.last  = blk_last;
`ifdef SHA_PAD_BLKCNT_EN
                    cur.index = blk_index;
`else
                    cur.index = '0;
`endif
                    if (blk_valid && prev_v && cur !== prev) unstable++;
                    if (blk_valid && blk_ready) begin
                        got.push_back(cur);
                        if (blk_last) done = 1'b1;
                        prev_v = 1'b0;
                    end else begin
                        prev_v = blk_valid;
                        prev   = cur;
                    end
                    step();
                    cyc++;
                end
                blk_ready = 1'b0;
                if (!done) timeout = 1'b1;
            end
        join
    endtask

    // One message end to end, checked block by block against the model.
    task automatic test_message(input string name, input byte_q_t msg, input int vpct, input int rpct);
        blk_q_t got;
        blk_q_t exp;
        int     unstable;
        bit     timeout;
        int     n;
        exp = model_blocks(msg);
        run_msg(msg, vpct, rpct, got, unstable, timeout);
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s timeout got=%0d exp=0", name, timeout);
        end
        total++;
        if (unstable !== 0) begin
            bad++;
            $display("FAIL %s stability changes got=%0d exp=0", name, unstable);
        end
        total++;
        if (got.size() !== exp.size()) begin
            bad++;
            $display("FAIL %s block count got=%0d exp=%0d", name, got.size(), exp.size());
        end
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int k = 0; k < n; k++) begin
            total++;
            if (got[k].data !== exp[k].data) begin
                bad++;
                $display("FAIL %s blk%0d data got=%h exp=%h", name, k, got[k].data, exp[k].data);
            end
            total++;
            if (got[k].first !== exp[k].first || got[k].last !== exp[k].last) begin
                bad++;
                $display("FAIL %s blk%0d first/last got=%b%b exp=%b%b", name, k,
                         got[k].first, got[k].last, exp[k].first, exp[k].last);
            end
`ifdef SHA_PAD_BLKCNT_EN
            total++;
            if (got[k].index !== exp[k].index) begin
                bad++;
                $display("FAIL %s blk%0d index got=%0d exp=%0d", name, k, got[k].index, exp[k].index);
            end
`endif
        end
        if (msg.size() == 3 && msg[0] == 8'h61 && got.size() > 0) begin
            total++;
            if (got[0].data !== ABC_BLK) begin
                bad++;
                $display("FAIL %s abc literal got=%h exp=%h", name, got[0].data, ABC_BLK);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        step();
        step();
        total++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_first !== 1'b0 || blk_last !== 1'b0) begin
            bad++;
            $display("FAIL reset flags got=%b%b%b%b exp=1000", in_ready, blk_valid, blk_first, blk_last);
        end
        total++;
        if (blk_data !== 512'h0) begin
            bad++;
            $display("FAIL reset data got=%h exp=0", blk_data);
        end
`ifdef SHA_PAD_BLKCNT_EN
        total++;
        if (blk_index !== 16'h0) begin
            bad++;
            $display("FAIL reset index got=%0d exp=0", blk_index);
        end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_boundaries();
        int      lens[7] = '{3, 1, 54, 55, 56, 63, 64};
        byte_q_t msg;
        for (int t = 0; t < 7; t++) begin
            msg = {};
            for (int i = 0; i < lens[t]; i++) msg.push_back((lens[t] == 3) ? 8'(8'h61 + i) : 8'h61);
            test_message($sformatf("len%0d", lens[t]), msg, 100, 100);
        end
        msg = {};
        for (int i = 0; i < 120; i++) msg.push_back(8'h61);
        test_message("len120", msg, 100, 100);
    endtask

    task automatic test_random();
        byte_q_t msg;
        int      len;
        for (int t = 0; t < 12; t++) begin
            msg = {};
            len = $urandom_range(200, 1);
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            test_message($sformatf("rand%0d_len%0d", t, len), msg,
                         $urandom_range(100, 40), $urandom_range(100, 30));
        end
    endtask

    task automatic test_backpressure();
        byte_q_t      abc = '{8'h61, 8'h62, 8'h63};
        byte_q_t      nxt = '{8'h11};
        logic [511:0] held;
        blk_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp idle in_ready got=%b exp=1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = abc[i];
            in_last  = (i == 2);
            step();
        end
        // Next message's first byte offered while the padder is busy.
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b0;
        total++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp pad cycle valid/ready got=%b%b exp=00", blk_valid, in_ready);
        end
        step();
        total++;
        if (blk_valid !== 1'b1 || blk_first !== 1'b1 || blk_last !== 1'b1) begin
            bad++;
            $display("FAIL bp latency valid/first/last got=%b%b%b exp=111", blk_valid, blk_first, blk_last);
        end
        total++;
        if (blk_data !== ABC_BLK) begin
            bad++;
            $display("FAIL bp data got=%h exp=%h", blk_data, ABC_BLK);
        end
        held = ABC_BLK;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (blk_data !== held || blk_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp hold%0d valid/ready got=%b%b exp=10 data got=%h", c, blk_valid, in_ready, blk_data);
            end
        end
        blk_ready = 1'b1;
        step();
        blk_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp release valid/ready got=%b%b exp=01", blk_valid, in_ready);
        end
        test_message("bp_next", nxt, 100, 100);
    endtask

    task automatic test_reset_mid();
        byte_q_t abc = '{8'h61, 8'h62, 8'h63};
        byte_q_t one = '{8'h5A};
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_data !== 512'h0) begin
            bad++;
            $display("FAIL rst_msg ready/valid got=%b%b exp=10 data got=%h", in_ready, blk_valid, blk_data);
        end
        test_message("rst_msg_abc", abc, 100, 100);
        // Reset while a block is waiting for the consumer.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = abc[i];
            in_last  = (i == 2);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        total++;
        if (blk_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_emit pre valid got=%b exp=1", blk_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (blk_valid !== 1'b0 || blk_last !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_emit valid/last/ready got=%b%b%b exp=001", blk_valid, blk_last, in_ready);
        end
        test_message("rst_emit_one", one, 100, 100);
    endtask

    task automatic test_back_to_back();
        byte_q_t a;
        byte_q_t b;
        for (int i = 0; i < 70; i++) a.push_back(8'($urandom));
        for (int i = 0; i < 10; i++) b.push_back(8'($urandom));
        test_message("b2b_first", a, 100, 100);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b in_ready after last got=%b exp=1", in_ready);
        end
        test_message("b2b_second", b, 100, 100);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        blk_ready = 1'b0;
        #1;
        test_reset();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
